// File: rtl/arima_pkg.sv
// Shared definitions for the ARIMA control sequencer: FSM states, the
// per-stage control codes understood by the datapath, and a sizing helper.
package arima_pkg;

  // Sequencer phases
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CLEAR     = 3'd1,
    ST_DIFF_FILL = 3'd2,
    ST_WARM      = 3'd3,
    ST_RUN       = 3'd4
  } state_e;

  // Stage control codes
  localparam logic [1:0] CODE_RUN  = 2'b00;
  localparam logic [1:0] CODE_LOAD = 2'b01;
  localparam logic [1:0] CODE_FILL = 2'b10;
  localparam logic [1:0] CODE_CLR  = 2'b11;

  // Largest of three orders; used to size the sample counter
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

endpackage

// File: rtl/arima_ctrl_seq.sv
// ARIMA control sequencer. Latches and validates (p, d, q) on start, then
// walks the datapath through clear, differencing fill, AR/MA warm-up and
// steady-state run. Every counter step is tied to an accepted input sample
// (in_valid & in_ready), so backpressure never drops or double-counts data.
// The control codes are Moore decodes of the state; the datapath applies
// them only on cycles where adv is high.
module arima_ctrl_seq
  import arima_pkg::*;
#(
  parameter int OW    = 32,
  parameter int MAX_P = 10,
  parameter int MAX_Q = 10,
  parameter int MAX_D = 2,
  parameter int CW    = $clog2(max3(MAX_P, MAX_Q, MAX_D) + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [OW-1:0] cfg_p,
  input  logic [OW-1:0] cfg_d,
  input  logic [OW-1:0] cfg_q,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          adv,
  output logic [1:0]    c_diff,
  output logic [1:0]    c_ar,
  output logic [1:0]    c_ma,
  output logic [1:0]    c_inte,
  output logic          sel_inte_in,
  output logic          out_valid,
  output logic          busy,
  output logic          cfg_err,
  output logic [CW-1:0] p_order,
  output logic [CW-1:0] d_order,
  output logic [CW-1:0] q_order
);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] p_ord_q, p_ord_d;
  logic [CW-1:0] d_ord_q, d_ord_d;
  logic [CW-1:0] q_ord_q, q_ord_d;
  logic          err_q, err_d;

  logic          order_ok_s;
  logic [CW-1:0] w_s;
  logic          last_fill_s;
  logic          last_warm_s;
  state_e        after_fill_s;

  // All three requested orders must fit what the datapath can hold
  assign order_ok_s = (cfg_p <= OW'(MAX_P)) &&
                      (cfg_q <= OW'(MAX_Q)) &&
                      (cfg_d <= OW'(MAX_D));

  // Warm-up length is the longer of the AR and MA histories
  assign w_s = (p_ord_q > q_ord_q) ? p_ord_q : q_ord_q;

  // Terminal counts; only consulted in states where the order is non-zero
  assign last_fill_s = (cnt_q == (d_ord_q - CW'(1)));
  assign last_warm_s = (cnt_q == (w_s - CW'(1)));

  // After differencing fill, skip warm-up entirely when both p and q are 0
  assign after_fill_s = (w_s != CW'(0)) ? ST_WARM : ST_RUN;

  // Handshake: the sequencer accepts samples in every data phase
  assign in_ready = (state_q == ST_DIFF_FILL) ||
                    (state_q == ST_WARM) ||
                    (state_q == ST_RUN);
  assign adv       = in_valid & in_ready;
  assign out_valid = adv & (state_q == ST_RUN);

  assign p_order = p_ord_q;
  assign d_order = d_ord_q;
  assign q_order = q_ord_q;
  assign cfg_err = err_q;

  // State, counter, latched orders and error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      p_ord_q <= '0;
      d_ord_q <= '0;
      q_ord_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_ord_q <= p_ord_d;
      d_ord_q <= d_ord_d;
      q_ord_q <= q_ord_d;
      err_q   <= err_d;
    end
  end

  // Next-state, counter and configuration-latch logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_ord_d = p_ord_q;
    d_ord_d = d_ord_q;
    q_ord_d = q_ord_q;
    err_d   = err_q;

    if (abort) begin
      // Abort wins over start and adv; orders and error flag are kept
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (order_ok_s) begin
              p_ord_d = cfg_p[CW-1:0];
              d_ord_d = cfg_d[CW-1:0];
              q_ord_d = cfg_q[CW-1:0];
              err_d   = 1'b0;
              state_d = ST_CLEAR;
            end else begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_CLEAR: begin
          cnt_d = '0;
          if (d_ord_q != CW'(0)) begin
            state_d = ST_DIFF_FILL;
          end else begin
            state_d = after_fill_s;
          end
        end

        ST_DIFF_FILL: begin
          if (adv) begin
            if (last_fill_s) begin
              cnt_d   = '0;
              state_d = after_fill_s;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            cnt_d = cnt_q;
          end
        end

        ST_WARM: begin
          if (adv) begin
            if (last_warm_s) begin
              cnt_d   = '0;
              state_d = ST_RUN;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            cnt_d = cnt_q;
          end
        end

        ST_RUN: begin
          state_d = ST_RUN;
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Moore decode of stage control codes, integrator source and busy
  always_comb begin
    c_diff      = CODE_CLR;
    c_ar        = CODE_CLR;
    c_ma        = CODE_CLR;
    c_inte      = CODE_CLR;
    sel_inte_in = 1'b1;
    busy        = 1'b1;

    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
      end

      ST_CLEAR: begin
        busy = 1'b1;
      end

      ST_DIFF_FILL: begin
        c_diff = CODE_FILL;
        c_ar   = CODE_LOAD;
        c_ma   = CODE_LOAD;
        c_inte = CODE_FILL;
      end

      ST_WARM: begin
        c_diff = CODE_RUN;
        if (cnt_q < p_ord_q) begin
          c_ar = CODE_FILL;
        end else begin
          c_ar = CODE_RUN;
        end
        c_ma   = CODE_FILL;
        c_inte = CODE_RUN;
      end

      ST_RUN: begin
        c_diff      = CODE_RUN;
        c_ar        = CODE_RUN;
        c_ma        = CODE_RUN;
        c_inte      = CODE_RUN;
        sel_inte_in = 1'b0;
      end

      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_arima_ctrl_seq.sv
// Self-checking bench for arima_ctrl_seq: a directed vector table, a few
// hand-written multi-cycle sequences, and a randomized run checked against
// a sample-count based reference model.
module tb_arima_ctrl_seq;

  localparam int OW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, start, abort, in_valid;
  logic [OW-1:0] cfg_p, cfg_d, cfg_q;
  logic          in_ready, adv, sel_inte_in, out_valid, busy, cfg_err;
  logic [1:0]    c_diff, c_ar, c_ma, c_inte;
  logic [CW-1:0] p_order, d_order, q_order;

  always #5 clk = ~clk;

  arima_ctrl_seq dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_p(cfg_p), .cfg_d(cfg_d), .cfg_q(cfg_q),
    .in_valid(in_valid), .in_ready(in_ready), .adv(adv),
    .c_diff(c_diff), .c_ar(c_ar), .c_ma(c_ma), .c_inte(c_inte),
    .sel_inte_in(sel_inte_in), .out_valid(out_valid), .busy(busy),
    .cfg_err(cfg_err), .p_order(p_order), .d_order(d_order), .q_order(q_order)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic a, input logic v,
                       input int p, input int d, input int q);
    start    = s;
    abort    = a;
    in_valid = v;
    cfg_p    = p;
    cfg_d    = d;
    cfg_q    = q;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       start, abort, valid;
    int         p, d, q;
    logic       e_busy, e_ready, e_adv;
    logic [7:0] e_codes;   // {c_diff, c_ar, c_ma, c_inte}
    logic       e_sel, e_ov, e_err;
  } vec_t;

  localparam int NV = 24;
  vec_t tv[NV];

  function automatic vec_t mk(input logic s, input logic a, input logic v,
                              input int p, input int d, input int q,
                              input logic b, input logic r, input logic ad,
                              input logic [7:0] c, input logic sl,
                              input logic ov, input logic er);
    vec_t t;
    t.start = s; t.abort = a; t.valid = v; t.p = p; t.d = d; t.q = q;
    t.e_busy = b; t.e_ready = r; t.e_adv = ad; t.e_codes = c;
    t.e_sel = sl; t.e_ov = ov; t.e_err = er;
    return t;
  endfunction

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 clear, 2 active; k counts samples accepted since clear
  int   m_mode, m_k, m_p, m_d, m_q;
  logic m_err;

  task automatic model_reset();
    m_mode = 0; m_k = 0; m_p = 0; m_d = 0; m_q = 0; m_err = 1'b0;
  endtask

  task automatic model_expect(input logic v, output logic b, output logic r,
                              output logic ad, output logic [7:0] c,
                              output logic sl, output logic ov);
    int w;
    w  = (m_p > m_q) ? m_p : m_q;
    b  = (m_mode != 0);
    r  = (m_mode == 2);
    ad = v && r;
    ov = 1'b0;
    sl = 1'b1;
    if (m_mode != 2) begin
      c = 8'hFF;
    end else if (m_k < m_d) begin
      c = 8'b10_01_01_10;
    end else if (m_k < m_d + w) begin
      c = ((m_k - m_d) < m_p) ? 8'b00_10_10_00 : 8'b00_00_10_00;
    end else begin
      c  = 8'h00;
      sl = 1'b0;
      ov = ad;
    end
  endtask

  task automatic model_step(input logic s, input logic a, input logic v,
                            input int p, input int d, input int q);
    if (a) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (s) begin
        if (p <= 10 && q <= 10 && d <= 2) begin
          m_p = p; m_d = d; m_q = q; m_err = 1'b0; m_mode = 1;
        end else begin
          m_err = 1'b1;
        end
      end
    end else if (m_mode == 1) begin
      m_mode = 2;
      m_k    = 0;
    end else if (v) begin
      m_k++;
    end
  endtask

  logic       e_b, e_r, e_ad, e_sl, e_ov;
  logic [7:0] e_c;
  logic       r_s, r_a, r_v;
  int         r_p, r_d, r_q;

  localparam logic [7:0] FF = 8'hFF;
  localparam logic [7:0] DF = 8'b10_01_01_10;
  localparam logic [7:0] W1 = 8'b00_10_10_00;
  localparam logic [7:0] W2 = 8'b00_00_10_00;
  localparam logic [7:0] RN = 8'h00;

  initial begin
    // start, abort, valid, p,d,q | busy, ready, adv, codes, sel, ov, err
    tv[0]  = mk(1,0,1,  2,1,3, 0,0,0, FF,1,0,0);
    tv[1]  = mk(0,0,1,  2,1,3, 1,0,0, FF,1,0,0);
    tv[2]  = mk(0,0,1,  2,1,3, 1,1,1, DF,1,0,0);
    tv[3]  = mk(0,0,1,  2,1,3, 1,1,1, W1,1,0,0);
    tv[4]  = mk(0,0,1,  2,1,3, 1,1,1, W1,1,0,0);
    tv[5]  = mk(0,0,1,  2,1,3, 1,1,1, W2,1,0,0);
    tv[6]  = mk(0,0,1,  2,1,3, 1,1,1, RN,0,1,0);
    tv[7]  = mk(1,0,1, 11,1,3, 1,1,1, RN,0,1,0);
    tv[8]  = mk(0,0,0,  2,1,3, 1,1,0, RN,0,0,0);
    tv[9]  = mk(0,1,0,  2,1,3, 1,1,0, RN,0,0,0);
    tv[10] = mk(1,0,0, 11,1,3, 0,0,0, FF,1,0,0);
    tv[11] = mk(0,0,0, 11,1,3, 0,0,0, FF,1,0,1);
    tv[12] = mk(1,0,1,  3,0,0, 0,0,0, FF,1,0,1);
    tv[13] = mk(0,0,1,  3,0,0, 1,0,0, FF,1,0,0);
    tv[14] = mk(0,0,1,  3,0,0, 1,1,1, W1,1,0,0);
    tv[15] = mk(0,0,0,  3,0,0, 1,1,0, W1,1,0,0);
    tv[16] = mk(0,0,1,  3,0,0, 1,1,1, W1,1,0,0);
    tv[17] = mk(0,0,1,  3,0,0, 1,1,1, W1,1,0,0);
    tv[18] = mk(0,0,1,  3,0,0, 1,1,1, RN,0,1,0);
    tv[19] = mk(0,1,0,  3,0,0, 1,1,0, RN,0,0,0);
    tv[20] = mk(1,0,1,  0,0,0, 0,0,0, FF,1,0,0);
    tv[21] = mk(0,0,1,  0,0,0, 1,0,0, FF,1,0,0);
    tv[22] = mk(0,0,1,  0,0,0, 1,1,1, RN,0,1,0);
    tv[23] = mk(0,0,0,  0,0,0, 1,1,0, RN,0,0,0);

    rst = 1'b1;
    drive(0,0,0,0,0,0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset.orders", {p_order, d_order, q_order}, 12'h000);
    check("reset.err", cfg_err, 1'b0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tv[i].start, tv[i].abort, tv[i].valid, tv[i].p, tv[i].d, tv[i].q);
      #1;
      check($sformatf("v%0d.busy", i),  busy,      tv[i].e_busy);
      check($sformatf("v%0d.ready", i), in_ready,  tv[i].e_ready);
      check($sformatf("v%0d.adv", i),   adv,       tv[i].e_adv);
      check($sformatf("v%0d.codes", i), {c_diff, c_ar, c_ma, c_inte}, tv[i].e_codes);
      check($sformatf("v%0d.sel", i),   sel_inte_in, tv[i].e_sel);
      check($sformatf("v%0d.ov", i),    out_valid, tv[i].e_ov);
      check($sformatf("v%0d.err", i),   cfg_err,   tv[i].e_err);
    end

    // abort in WARM at cnt=1, then a fresh start replays warm-up
    @(negedge clk); drive(0,1,0,0,0,0);
    @(negedge clk); drive(1,0,1,2,0,2); #1;
    check("ab.idle_busy", busy, 1'b0);
    @(negedge clk); drive(0,0,1,2,0,2); #1;
    check("ab.clear_busy", busy, 1'b1);
    @(negedge clk); #1;
    check("ab.warm0_ar", c_ar, 2'b10);
    @(negedge clk); drive(0,1,1,2,0,2); #1;
    check("ab.warm1_ar", c_ar, 2'b10);
    check("ab.warm1_ov", out_valid, 1'b0);
    @(negedge clk); drive(0,0,1,2,0,2); #1;
    check("ab.idle_codes", {c_diff, c_ar, c_ma, c_inte}, 8'hFF);
    check("ab.idle_busy2", busy, 1'b0);
    check("ab.orders_kept", {p_order, d_order, q_order}, 12'h202);
    drive(1,0,1,2,0,2);
    @(negedge clk); drive(0,0,1,2,0,2); #1;
    check("ab.re_clear", {c_diff, c_ar, c_ma, c_inte}, 8'hFF);
    @(negedge clk); #1;
    check("ab.re_warm0", {c_diff, c_ar, c_ma, c_inte}, 8'b00_10_10_00);
    check("ab.re_warm0_ov", out_valid, 1'b0);
    @(negedge clk); #1;
    check("ab.re_warm1", {c_diff, c_ar, c_ma, c_inte}, 8'b00_10_10_00);
    check("ab.re_warm1_ov", out_valid, 1'b0);
    @(negedge clk); #1;
    check("ab.re_run_ov", out_valid, 1'b1);
    check("ab.re_run_sel", sel_inte_in, 1'b0);

    // rst mid-RUN together with start and abort
    @(negedge clk); rst = 1'b1; drive(1,1,1,11,1,3);
    @(negedge clk); rst = 1'b0; drive(0,0,1,0,0,0); #1;
    check("rst.busy", busy, 1'b0);
    check("rst.ready", in_ready, 1'b0);
    check("rst.adv", adv, 1'b0);
    check("rst.codes", {c_diff, c_ar, c_ma, c_inte}, 8'hFF);
    check("rst.sel", sel_inte_in, 1'b1);
    check("rst.ov", out_valid, 1'b0);
    check("rst.err", cfg_err, 1'b0);
    check("rst.orders", {p_order, d_order, q_order}, 12'h000);

    // rst clears a pending cfg_err
    drive(1,0,0,3,3,3);
    @(negedge clk); drive(0,0,0,0,0,0); #1;
    check("err.set", cfg_err, 1'b1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    check("err.rst", cfg_err, 1'b0);

    // randomized run against the reference model
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      r_s = ($urandom_range(0, 9) == 0);
      r_a = ($urandom_range(0, 59) == 0);
      r_v = r_a ? 1'b0 : ($urandom_range(0, 9) < 7);
      r_p = $urandom_range(0, 11);
      r_d = $urandom_range(0, 3);
      r_q = $urandom_range(0, 11);
      drive(r_s, r_a, r_v, r_p, r_d, r_q);
      #1;
      model_expect(r_v, e_b, e_r, e_ad, e_c, e_sl, e_ov);
      check($sformatf("rnd%0d.busy", c),  busy, e_b);
      check($sformatf("rnd%0d.ready", c), in_ready, e_r);
      check($sformatf("rnd%0d.adv", c),   adv, e_ad);
      check($sformatf("rnd%0d.codes", c), {c_diff, c_ar, c_ma, c_inte}, e_c);
      check($sformatf("rnd%0d.sel", c),   sel_inte_in, e_sl);
      check($sformatf("rnd%0d.ov", c),    out_valid, e_ov);
      check($sformatf("rnd%0d.err", c),   cfg_err, m_err);
      check($sformatf("rnd%0d.orders", c), {p_order, d_order, q_order},
            {4'(m_p), 4'(m_d), 4'(m_q)});
      model_step(r_s, r_a, r_v, r_p, r_d, r_q);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/arima_ctrl_seq.md
Name: arima_ctrl_seq

Overview:
Parametrised sequencer for the ARIMA datapath. It latches model orders (p, d, q) on start and validates them. It drives the per-stage control codes for the differencer, AR, MA and integrator stages through clear, differencing fill, AR/MA warm-up and steady-state run. Unlike the fixed first-generation controller, every counter advances only on an accepted input sample (valid/ready handshake), and the block also provides order checking, abort and an output-valid qualifier.

Parameters:
OW, 32, width of order inputs cfg_p/cfg_d/cfg_q
MAX_P, 10, maximum AR order supported by datapath
MAX_Q, 10, maximum MA order supported by datapath
MAX_D, 2, maximum differencing order
CW, $clog2(max(MAX_P,MAX_Q,MAX_D)+1), internal sample-counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  begin sequence; sampled only in IDLE
abort  in  1  return to IDLE from any state
cfg_p  in  OW  AR order
cfg_d  in  OW  differencing order
cfg_q  in  OW  MA order
in_valid  in  1  upstream sample available
in_ready  out  1  sequencer accepts sample this cycle
adv  out  1  in_valid & in_ready; datapath stages update only when high
c_diff  out  2  differencer control code
c_ar  out  2  AR stage control code
c_ma  out  2  MA stage control code
c_inte  out  2  integrator control code
sel_inte_in  out  1  1 = integrator takes raw input, 0 = model output
out_valid  out  1  datapath output valid this cycle
busy  out  1  high in every state except IDLE
cfg_err  out  1  sticky: last start carried an out-of-range order
p_order, d_order, q_order  out  CW each  latched orders

Behaviour:
- Control codes (shared package): RUN=00, LOAD=01, FILL=10, CLR=11. Codes are Moore outputs of the state register and qualified by adv in fill states.
- Reset: state IDLE, cnt 0, latched orders 0, cfg_err 0. Outputs: c_*=11, sel_inte_in=1, in_ready=0, adv=0, out_valid=0, busy=0.
- IDLE: c_*=CLR, sel_inte_in=1, in_ready=0.
  - start with cfg_p<=MAX_P, cfg_q<=MAX_Q, cfg_d<=MAX_D: latch orders (truncated to CW), clear cfg_err, go to CLEAR.
  - start with any order out of range: set cfg_err, stay in IDLE.
- CLEAR (exactly 1 cycle): c_*=CLR, in_ready=0, cnt:=0.
  - Next state: DIFF_FILL if d>0; else WARM if W>0, where W=max(p,q); else RUN.
- DIFF_FILL: in_ready=1; c_diff=FILL, c_ar=LOAD, c_ma=LOAD, c_inte=FILL, sel_inte_in=1.
  - On adv: cnt++. When adv and cnt==d-1: cnt:=0, go to WARM if W>0, else RUN.
- WARM: in_ready=1; c_diff=RUN, c_ar=FILL while cnt<p else RUN, c_ma=FILL, c_inte=RUN, sel_inte_in=1.
  - On adv: cnt++. When adv and cnt==W-1: cnt:=0, go to RUN.
- RUN: in_ready=1, c_*=RUN, sel_inte_in=0, out_valid=adv. The block stays in RUN until abort or rst.
- No adv, in any state: cnt and state hold (except CLEAR and IDLE transitions). No sample is ever lost or double-counted under backpressure.
- abort: next state IDLE, cnt:=0, latched orders kept, cfg_err unchanged. Takes priority over start and adv; rst takes priority over abort.
- start while busy: ignored.
- Latency: start to first in_ready = 2 cycles. First out_valid occurs on accepted sample number d+W+1.
- Orders of 0 are legal; p=d=q=0 goes CLEAR to RUN directly.

Decomposition:
- arima_pkg: state enum (IDLE, CLEAR, DIFF_FILL, WARM, RUN), control-code localparams (RUN, LOAD, FILL, CLR), and a max3 function for CW.
- No sub-module. The counter and order check are inline; the whole block is a single FSM plus counter, about 200 lines.

Test Plan:
- p=2,d=1,q=3, in_valid tied 1, start at cycle 0 -> CLEAR at cycle 1; DIFF_FILL for 1 sample; WARM for 3 samples, with c_ar=10 for the first 2 and 00 for the 3rd; RUN; out_valid first high on the 5th accepted sample; sel_inte_in falls to 0 on entry to RUN.
- Same config, in_valid toggling 1,0,0,1,... -> cnt and state advance only on adv cycles; the 5th accepted sample still produces the first out_valid.
- p=11 (MAX_P=10), start -> cfg_err=1, busy=0, state IDLE. Then p=3 with start -> cfg_err=0, sequence runs.
- p=d=q=0, start -> IDLE, CLEAR, RUN in consecutive cycles; out_valid equals in_valid from the 3rd cycle.
- abort asserted during WARM at cnt=1 -> IDLE the next cycle with c_*=11 and cnt=0. A fresh start replays the full warm-up.
- rst asserted mid-RUN, together with start and abort -> all outputs at reset values the next cycle, state IDLE, cfg_err=0.
